// File: rtl/keypad_scanner_pkg.sv
// Shared encodings and helpers for the 4x4 keypad scanner.
// Column/row helpers decode active-low one-cold vectors.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [3:0] COL_IDLE_RST = 4'b1110;
  localparam int         KEY_W        = 4;

  function automatic logic [3:0] col_rotate(input logic [3:0] col_n);
    return {col_n[2:0], col_n[3]};
  endfunction

  // Index of the lowest low bit; a vector with no low bit maps to 3.
  function automatic logic [1:0] lowest_low(input logic [3:0] vec_n);
    if (!vec_n[0])      return 2'd0;
    else if (!vec_n[1]) return 2'd1;
    else if (!vec_n[2]) return 2'd2;
    else                return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins and the key-event outputs of the scanner.
// Handshake: key_valid is a one-cycle strobe qualifying key_code; there is no ready, the consumer must take it.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;

  logic [3:0]       row_in;
  logic [3:0]       col_out;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;
  state_t           state_dbg;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_held, state_dbg
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_held, state_dbg
  );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Parameterised-width two-flop synchroniser with synchronous active-low reset.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: tick-paced column scan, debounce, one key code per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_RATE    = 16
) (
  input  logic clk,
  input  logic rst_a,
  keypad_scanner_if.master kp
);

  localparam int TICK_W = $clog2(SCAN_DIV + 1);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0]        row_s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  state_t            state;
  logic [3:0]        col_out;
  logic [KEY_W-1:0]  key_code;
  logic              key_valid;
  logic              key_held;
  logic [1:0]        cand_row;
  logic [1:0]        cand_col;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rcnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  rcnt_inc;
  logic              accept;
  logic [1:0]        acc_row;
  logic              cand_low;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .rst_a (rst_a),
    .d     (kp.row_in),
    .q     (row_s)
  );

  assign tick = (tick_cnt == TICK_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_a || tick) tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + 1'b1;
  end

  assign cand_low = !row_s[cand_row];
  assign cnt_inc  = (cnt  == CNT_W'(DEBOUNCE_SCANS)) ? cnt  : cnt  + 1'b1;
  assign rcnt_inc = (rcnt == CNT_W'(DEBOUNCE_SCANS)) ? rcnt : rcnt + 1'b1;

  // A press is accepted straight from SCAN when a single matching tick suffices.
  always_comb begin
    accept  = 1'b0;
    acc_row = cand_row;
    if (tick) begin
      if (state == ST_SCAN && row_s != 4'hF && DEBOUNCE_SCANS == 1) begin
        accept  = 1'b1;
        acc_row = lowest_low(row_s);
      end else if (state == ST_DEBOUNCE && cand_low && cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
        accept  = 1'b1;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_inc;
  assign rep_inc = rep_cnt + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state     <= ST_SCAN;
      col_out   <= COL_IDLE_RST;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      cand_row  <= '0;
      cand_col  <= '0;
      cnt       <= '0;
      rcnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (row_s == 4'hF) begin
              col_out <= col_rotate(col_out);
            end else begin
              cand_col <= lowest_low(col_out);
              cand_row <= lowest_low(row_s);
              cnt      <= CNT_W'(1);
              state    <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (cand_low) begin
              cnt <= cnt_inc;
            end else begin
              cnt     <= '0;
              col_out <= col_rotate(col_out);
              state   <= ST_SCAN;
            end
          end
          ST_HELD: begin
            if (!cand_low) begin
              if (rcnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                rcnt     <= '0;
                key_held <= 1'b0;
                col_out  <= col_rotate(col_out);
                state    <= ST_SCAN;
              end else begin
                rcnt <= rcnt_inc;
              end
            end else begin
              rcnt <= '0;
`ifdef KEYPAD_REPEAT_EN
              // After the first repeat the counter parks at REPEAT_DELAY and re-arms every REPEAT_RATE ticks.
              if (rep_inc == REP_W'(REPEAT_DELAY + REPEAT_RATE)) begin
                rep_cnt   <= REP_W'(REPEAT_DELAY);
                key_valid <= 1'b1;
              end else begin
                rep_cnt <= rep_inc;
                if (rep_inc == REP_W'(REPEAT_DELAY)) key_valid <= 1'b1;
              end
`endif
            end
          end
          default: state <= ST_SCAN;
        endcase
      end

      if (accept) begin
        key_code  <= {acc_row, lowest_low(col_out)};
        cand_row  <= acc_row;
        key_held  <= 1'b1;
        key_valid <= 1'b1;
        cnt       <= '0;
        rcnt      <= '0;
        state     <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt   <= '0;
`endif
      end
    end
  end

  assign kp.col_out   = col_out;
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = key_held;
  assign kp.state_dbg = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a behavioural 4x4 matrix model and a key-code scoreboard.
// Build with KEYPAD_REPEAT_EN defined to also check the auto-repeat schedule.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0]  row_model;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  exp_q[$];
  int          vcyc[$];

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (4)
  ) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .kp    (kp)
  );

  // ---- clock / reset bookkeeping ----
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_a) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col_out[c]) row_model[r] = 1'b0;
  end
  assign kp.row_in = row_model;

  // ---- scoreboard monitor ----
  always @(negedge clk) begin
    if (rst_a && kp.key_valid) begin
      vcyc.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL key_valid_unexpected: got code %0h, expected no pulse (cyc %0d)", kp.key_code, cyc);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (kp.key_code !== e || kp.key_held !== 1'b1) begin
          miscompares++;
          $display("FAIL key_event: got code %0h held %b, expected code %0h held 1", kp.key_code, kp.key_held, e);
        end
      end
    end
  end

  // ---- driver / check tasks ----
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_held(input logic v, input int limit, input string name);
    int n = 0;
    while (kp.key_held !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(kp.key_held), 32'(v));
  endtask

  task automatic wait_col(input logic [3:0] target, input string name);
    int n = 0;
    while (!(kp.col_out == target && cyc % 4 == 0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(kp.col_out), 32'(target));
  endtask

  task automatic release_and_time(input string name);
    int n = 0;
    while (cyc % 4 != 0) @(negedge clk);
    pressed = '0;
    do begin
      @(negedge clk);
      n++;
    end while (kp.key_held && n < 60);
    check(name, 32'(n), 32'd12);
  endtask

  // ---- stimulus ----
  initial begin
    logic [3:0] prev_col;
    int changes;
    int last_change;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_col_out", 32'(kp.col_out), 32'h0E);
    check("rst_key_code", 32'(kp.key_code), 32'h0);
    check("rst_key_valid", 32'(kp.key_valid), 32'h0);
    check("rst_key_held", 32'(kp.key_held), 32'h0);
    rst_a = 1'b1;

    // 2: idle scan, column rotates every 4 clk
    prev_col = kp.col_out;
    changes = 0;
    last_change = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (kp.col_out != prev_col) begin
        check("scan_rotate", 32'(kp.col_out), 32'({prev_col[2:0], prev_col[3]}));
        if (last_change >= 0) check("scan_interval", 32'(i - last_change), 32'd4);
        last_change = i;
        changes++;
        prev_col = kp.col_out;
      end
    end
    check("scan_changes", 32'(changes), 32'd8);

    // 3: row2/col1 -> code 9, held falls 3 ticks after release
    exp_q.push_back(4'h9);
    pressed[9] = 1'b1;
    wait_held(1'b1, 200, "press9_held");
    repeat (8) @(negedge clk);
    release_and_time("press9_release_delay");

    // 4: one-tick glitch on row0/col2 -> no key, scan resumes at col 3
    wait_col(4'b1011, "glitch_at_col2");
    pressed[2] = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_col_frozen", 32'(kp.col_out), 32'h0B);
    pressed = '0;
    repeat (4) @(negedge clk);
    check("glitch_resume_col3", 32'(kp.col_out), 32'h07);
    check("glitch_state_scan", 32'(kp.state_dbg), 32'(ST_SCAN));

    // 5: rows 1 and 2 on col 3 -> lowest row wins (code 7)
    exp_q.push_back(4'h7);
    pressed[7] = 1'b1;
    pressed[11] = 1'b1;
    wait_held(1'b1, 200, "press7_held");
    check("press7_code", 32'(kp.key_code), 32'h7);
    repeat (4) @(negedge clk);
    release_and_time("press7_release_delay");

    // 6: hold key 5 for 30 ticks, then reset while held
    vcyc.delete();
    exp_q.push_back(4'h5);
`ifdef KEYPAD_REPEAT_EN
    for (int k = 0; k < 6; k++) exp_q.push_back(4'h5);
`endif
    pressed[5] = 1'b1;
    wait_held(1'b1, 200, "press5_held");
    repeat (120) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
    check("repeat_pulse_count", 32'(vcyc.size()), 32'd7);
    for (int k = 1; k < vcyc.size(); k++)
      check("repeat_interval", 32'(vcyc[k] - vcyc[k-1]), (k == 1) ? 32'd32 : 32'd16);
`else
    check("single_pulse_count", 32'(vcyc.size()), 32'd1);
`endif
    rst_a = 1'b0;
    @(negedge clk);
    check("midheld_rst_held", 32'(kp.key_held), 32'h0);
    check("midheld_rst_col", 32'(kp.col_out), 32'h0E);
    check("midheld_rst_valid", 32'(kp.key_valid), 32'h0);
    check("midheld_rst_code", 32'(kp.key_code), 32'h0);
    pressed = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (40) @(negedge clk);

    // ---- final report ----
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
